// File: rtl/wino_pkg.sv
// Shared constants and types for the Winograd F(2x2,3x3) output-transform stream.
package wino_pkg;

  localparam int unsigned WINO_ROWS = 4;
  localparam int unsigned WINO_OUT  = 2;

  typedef logic [1:0] row_idx_t;

  // Nine-term sums need four guard bits over the input width.
  function automatic int unsigned wino_min_out_w(input int unsigned data_w);
    return data_w + 4;
  endfunction

endpackage

// File: rtl/wino_row_a.sv
// Combinational row transform Z[r]·A: a = z0+z1+z2, b = z1-z2-z3 at the widened output width.
module wino_row_a #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned OUT_W  = 24
) (
  input  logic [DATA_W-1:0] din0_i,
  input  logic [DATA_W-1:0] din1_i,
  input  logic [DATA_W-1:0] din2_i,
  input  logic [DATA_W-1:0] din3_i,
  output logic [OUT_W-1:0]  a_o,
  output logic [OUT_W-1:0]  b_o
);

  logic signed [OUT_W-1:0] z0, z1, z2, z3;

  assign z0 = OUT_W'($signed(din0_i));
  assign z1 = OUT_W'($signed(din1_i));
  assign z2 = OUT_W'($signed(din2_i));
  assign z3 = OUT_W'($signed(din3_i));

  assign a_o = z0 + z1 + z2;
  assign b_o = z1 - z2 - z3;

endmodule

// File: rtl/wino_atza_stream.sv
// Streaming Winograd output transform: four row beats of Z in, one 2x2 tile Y = AT·Z·A out.
module wino_atza_stream
  import wino_pkg::*;
#(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned OUT_W  = wino_min_out_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  dout0,
  output logic [OUT_W-1:0]  dout1,
  output logic [OUT_W-1:0]  dout2,
  output logic [OUT_W-1:0]  dout3
);

  localparam row_idx_t LastRow = row_idx_t'(WINO_ROWS - 1);

  row_idx_t                row_q, row_d;
  logic signed [OUT_W-1:0] acc0_q [WINO_OUT];
  logic signed [OUT_W-1:0] acc0_d [WINO_OUT];
  logic signed [OUT_W-1:0] acc1_q [WINO_OUT];
  logic signed [OUT_W-1:0] acc1_d [WINO_OUT];
  logic signed [OUT_W-1:0] out_q  [4];
  logic signed [OUT_W-1:0] out_d  [4];
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] a, b;
  logic                    accept;

  wino_row_a #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W)
  ) u_row_a (
    .din0_i(din0),
    .din1_i(din1),
    .din2_i(din2),
    .din3_i(din3),
    .a_o   (a),
    .b_o   (b)
  );

  // Only the tile-completing beat needs a free output slot.
  assign in_ready = (row_q != LastRow) | ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    row_d       = row_q;
    acc0_d      = acc0_q;
    acc1_d      = acc1_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      row_d       = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < WINO_OUT; i++) begin
        acc0_d[i] = '0;
        acc1_d[i] = '0;
      end
    end else if (accept) begin
      row_d = row_q + row_idx_t'(1);
      case (row_q)
        2'd0: begin
          acc0_d[0] = a;
          acc0_d[1] = b;
          acc1_d[0] = '0;
          acc1_d[1] = '0;
        end
        2'd1: begin
          acc0_d[0] = acc0_q[0] + a;
          acc0_d[1] = acc0_q[1] + b;
          acc1_d[0] = acc1_q[0] + a;
          acc1_d[1] = acc1_q[1] + b;
        end
        2'd2: begin
          acc0_d[0] = acc0_q[0] + a;
          acc0_d[1] = acc0_q[1] + b;
          acc1_d[0] = acc1_q[0] - a;
          acc1_d[1] = acc1_q[1] - b;
        end
        default: begin
          acc1_d[0]   = acc1_q[0] - a;
          acc1_d[1]   = acc1_q[1] - b;
          out_d[0]    = acc0_q[0];
          out_d[1]    = acc0_q[1];
          out_d[2]    = acc1_q[0] - a;
          out_d[3]    = acc1_q[1] - b;
          out_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < WINO_OUT; i++) begin
        acc0_q[i] <= '0;
        acc1_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      acc0_q      <= acc0_d;
      acc1_q      <= acc1_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout0     = out_q[0];
  assign dout1     = out_q[1];
  assign dout2     = out_q[2];
  assign dout3     = out_q[3];

endmodule

// File: tb/tb_wino_atza_stream.sv
// Self-checking bench for wino_atza_stream: matrix-level AT·Z·A model, directed and random tiles.
module tb_wino_atza_stream;

  localparam int DATA_W = 20;
  localparam int OUT_W  = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  dout0, dout1, dout2, dout3;

  int n_tests = 0;
  int n_fail  = 0;
  int or_mode = 0;  // 0: always ready, 1: random, 2: stalled

  typedef struct {
    longint y[4];
  } tile_t;

  tile_t exp_q[$];
  int    zt[4][4];

  always #5 clk = ~clk;

  wino_atza_stream #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .din2     (din2),
    .din3     (din3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout0    (dout0),
    .dout1    (dout1),
    .dout2    (dout2),
    .dout3    (dout3)
  );

  // Y = AT * Z * A with AT = [[1,1,1,0],[0,1,-1,-1]] and A = AT transposed.
  function automatic tile_t model(input int z[4][4]);
    int    at[2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
    tile_t t;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        longint s = 0;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            s += longint'(at[i][r] * at[j][c]) * longint'(z[r][c]);
          end
        end
        t.y[i*2+j] = s;
      end
    end
    return t;
  endfunction

  function automatic longint sx(input logic [OUT_W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_dout(input string name, input longint e0, input longint e1,
                            input longint e2, input longint e3);
    check({name, "_valid"}, longint'(out_valid), 1);
    check({name, "_d0"}, sx(dout0), e0);
    check({name, "_d1"}, sx(dout1), e1);
    check({name, "_d2"}, sx(dout2), e2);
    check({name, "_d3"}, sx(dout3), e3);
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) zt[r][c] = v;
  endtask

  task automatic rand_tile();
    int kind = $urandom_range(0, 7);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (kind == 0)      zt[r][c] = -(1 << (DATA_W - 1));
        else if (kind == 1) zt[r][c] = (1 << (DATA_W - 1)) - 1;
        else zt[r][c] = int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
      end
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after the beat is taken.
  task automatic send_row(input int r, input int max_gap, output int stalls);
    int n = 0;
    if (max_gap > 0 && $urandom_range(0, 2) == 0) n = $urandom_range(1, max_gap);
    repeat (n) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    din0 = DATA_W'(zt[r][0]);
    din1 = DATA_W'(zt[r][1]);
    din2 = DATA_W'(zt[r][2]);
    din3 = DATA_W'(zt[r][3]);
    #1;
    stalls = 0;
    while (!in_ready && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", longint'(in_ready), 1);
    end else if (r == 3) begin
      exp_q.push_back(model(zt));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input int max_gap);
    int st;
    for (int r = 0; r < 4; r++) send_row(r, max_gap, st);
  endtask

  task automatic wait_empty();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("drain_empty", longint'(exp_q.size()), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Every cycle an output is presented it must equal the oldest outstanding model tile.
  initial begin
    tile_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", longint'(out_valid), 0);
        end else begin
          e = exp_q[0];
          check("model_d0", sx(dout0), e.y[0]);
          check("model_d1", sx(dout1), e.y[1]);
          check("model_d2", sx(dout2), e.y[2]);
          check("model_d3", sx(dout3), e.y[3]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int st;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_d0", sx(dout0), 0);
    check("rst_d1", sx(dout1), 0);
    check("rst_d2", sx(dout2), 0);
    check("rst_d3", sx(dout3), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed tiles: output must be visible on the edge that takes row 3.
    fill(1);
    send_tile(0);
    check_dout("ones", 9, -3, -3, 1);

    fill(0);
    zt[0][0] = 5;
    send_tile(0);
    check_dout("z00", 5, 0, 0, 0);

    fill(0);
    zt[3][3] = 2;
    send_tile(0);
    check_dout("z33", 0, 0, 0, 2);

    fill(-524288);
    send_tile(0);
    check_dout("minval", -4718592, 1572864, 1572864, -524288);

    // Back-pressure across two tiles.
    wait_empty();
    or_mode = 2;
    repeat (2) @(negedge clk);
    fill(1);
    send_tile(0);
    check("bp_t1_valid", longint'(out_valid), 1);
    fill(0);
    zt[0][0] = 5;
    for (int r = 0; r < 3; r++) begin
      send_row(r, 0, st);
      check("bp_row_no_stall", longint'(st), 0);
    end
    in_valid = 1'b1;
    din0 = DATA_W'(zt[3][0]);
    din1 = DATA_W'(zt[3][1]);
    din2 = DATA_W'(zt[3][2]);
    din3 = DATA_W'(zt[3][3]);
    repeat (3) begin
      #1;
      check("bp_row3_stall", longint'(in_ready), 0);
      check("bp_hold_d0", sx(dout0), 9);
      @(negedge clk);
    end
    or_mode = 0;
    send_row(3, 0, st);
    check_dout("bp_t2", 5, 0, 0, 0);

    // Clear after row 2 drops the partial tile and the beat presented with it.
    wait_empty();
    rand_tile();
    for (int r = 0; r < 3; r++) send_row(r, 0, st);
    clear    = 1'b1;
    in_valid = 1'b1;
    din0     = DATA_W'(7);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    repeat (5) begin
      check("clear_no_out", longint'(out_valid), 0);
      @(negedge clk);
    end
    rand_tile();
    send_tile(0);
    check("clear_fresh_valid", longint'(out_valid), 1);

    // Asynchronous reset mid-tile.
    wait_empty();
    rand_tile();
    send_row(0, 0, st);
    send_row(1, 0, st);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    check("mid_rst_d0", sx(dout0), 0);
    check("mid_rst_d1", sx(dout1), 0);
    check("mid_rst_d2", sx(dout2), 0);
    check("mid_rst_d3", sx(dout3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_tile();
    send_tile(0);
    check("rst_fresh_valid", longint'(out_valid), 1);

    // Random gaps and random back-pressure.
    wait_empty();
    or_mode = 1;
    repeat (1000) begin
      rand_tile();
      send_tile(2);
    end
    or_mode = 0;
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
